// File: rtl/inv_cipher_iterative_pkg.sv
// Shared constants, FSM encoding and GF(2^8) helpers for the iterative AES inverse cipher.
package inv_cipher_iterative_pkg;

    localparam int NB_STATE = 128;
    localparam int N_COLS   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_t;

    // Multiply by x modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = '0;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = gf_mul2(x);
        end
        return acc;
    endfunction

    // a^254 is the multiplicative inverse (and maps 0 to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] t;
        r = 8'h01;
        t = a;
        for (int i = 1; i < 8; i++) begin
            t = gf_mul(t, t);
            r = gf_mul(r, t);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2    = gf_mul2(a[i]);
            x4    = gf_mul2(x2);
            x8    = gf_mul2(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

endpackage

// File: rtl/inv_cipher_iterative_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, optional InvMixColumns.
module inv_round_block
    import inv_cipher_iterative_pkg::*;
(
    output logic [NB_STATE-1:0] o_state,
    input  logic [NB_STATE-1:0] i_state,
    input  logic [NB_STATE-1:0] i_round_key,
    input  logic                i_last
);

    logic [NB_STATE-1:0] sub_state;
    logic [NB_STATE-1:0] keyed_state;
    logic [NB_STATE-1:0] mixed_state;

    // Byte r+4c of the result comes from row r, column (c-r) mod 4 of the input.
    // NOTE: every always_comb output is given a default first so no latch can be inferred.
    always_comb begin
        sub_state = '0;
        for (int c = 0; c < N_COLS; c++) begin
            for (int r = 0; r < 4; r++) begin
                sub_state[NB_STATE-1-8*(r+4*c) -: 8] =
                    inv_sbox(i_state[NB_STATE-1-8*(r+4*((c-r+4)%4)) -: 8]);
            end
        end
    end

    assign keyed_state = sub_state ^ i_round_key;

    always_comb begin
        mixed_state = '0;
        for (int c = 0; c < N_COLS; c++) begin
            mixed_state[NB_STATE-1-32*c -: 32] = inv_mix_column(keyed_state[NB_STATE-1-32*c -: 32]);
        end
    end

    assign o_state = i_last ? keyed_state : mixed_state;

endmodule

// File: rtl/inv_cipher_iterative.sv
// Iterative AES inverse cipher: one inverse round per clock over a shared round datapath.
module inv_cipher_iterative
    import inv_cipher_iterative_pkg::*;
#(
    parameter int NB_BYTE  = 8,
    parameter int N_BYTES  = 16,
    parameter int N_ROUNDS = 14
) (
    input  logic                             i_clock,
    input  logic                             i_reset,
    input  logic [NB_STATE-1:0]              i_data,
    input  logic [NB_STATE*(N_ROUNDS+1)-1:0] i_round_keys,
    input  logic                             i_valid,
    output logic                             o_ready,
    output logic [NB_STATE-1:0]              o_data,
    output logic                             o_valid,
    input  logic                             i_ready
);

    localparam int CNT_W = $clog2(N_ROUNDS);

    if (NB_BYTE != 8 || N_BYTES != 16 ||
        !(N_ROUNDS == 10 || N_ROUNDS == 12 || N_ROUNDS == 14)) begin : g_bad_params
        $error("inv_cipher_iterative: NB_BYTE must be 8, N_BYTES 16, N_ROUNDS 10/12/14");
    end

    fsm_state_t                   fsm_q;
    logic [CNT_W-1:0]             cnt_q;
    logic [NB_STATE-1:0]          state_q;
    logic [NB_STATE*N_ROUNDS-1:0] key_q;
    logic [NB_STATE-1:0]          round_key;
    logic [NB_STATE-1:0]          round_out;
    logic                         last_round;
    logic                         accept;

    assign o_ready    = (fsm_q == ST_IDLE) | ((fsm_q == ST_DONE) & i_ready);
    assign accept     = i_valid & o_ready;
    assign last_round = (cnt_q == '0);
    assign round_key  = key_q[cnt_q*NB_STATE +: NB_STATE];

    inv_round_block u_round (
        .o_state     (round_out),
        .i_state     (state_q),
        .i_round_key (round_key),
        .i_last      (last_round)
    );

    // NOTE: the key register has no reset; it is always loaded on acceptance before being read.
    always_ff @(posedge i_clock) begin
        if (accept) key_q <= i_round_keys[NB_STATE*N_ROUNDS-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            fsm_q   <= ST_IDLE;
            cnt_q   <= '0;
            state_q <= '0;
            o_data  <= '0;
            o_valid <= 1'b0;
        end else if (accept) begin
            // Acceptance in DONE also consumes the pending output on the same edge.
            state_q <= i_data ^ i_round_keys[N_ROUNDS*NB_STATE +: NB_STATE];
            cnt_q   <= CNT_W'(N_ROUNDS - 1);
            o_valid <= 1'b0;
            fsm_q   <= ST_BUSY;
        end else begin
            case (fsm_q)
                ST_IDLE: fsm_q <= ST_IDLE;
                ST_BUSY: begin
                    state_q <= round_out;
                    if (last_round) begin
                        o_data  <= round_out;
                        o_valid <= 1'b1;
                        fsm_q   <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        fsm_q   <= ST_IDLE;
                    end
                end
                default: fsm_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_cipher_iterative.sv
// Self-checking bench: FIPS-197 vectors, handshake scenarios and a forward-cipher-model regression.
module tb_inv_cipher_iterative;

    localparam int KW256 = 128*15;
    localparam int KW128 = 128*11;
    localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CT_128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] KEY_256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};

    logic             clk = 1'b0;
    logic             rst = 1'b1;

    logic [127:0]     a_data   = '0;
    logic [KW256-1:0] a_keys   = '0;
    logic             a_valid  = 1'b0;
    logic             a_iready = 1'b0;
    logic             a_ready;
    logic [127:0]     a_odata;
    logic             a_ovalid;

    logic [127:0]     b_data   = '0;
    logic [KW128-1:0] b_keys   = '0;
    logic             b_valid  = 1'b0;
    logic             b_iready = 1'b0;
    logic             b_ready;
    logic [127:0]     b_odata;
    logic             b_ovalid;

    int               errors = 0;
    int               checks = 0;
    logic [7:0]       sbox [256];
    logic [KW256-1:0] rk256;
    logic [KW256-1:0] rk128;

    always #5 clk = ~clk;

    inv_cipher_iterative #(.NB_BYTE(8), .N_BYTES(16), .N_ROUNDS(14)) dut256 (
        .i_clock(clk), .i_reset(rst), .i_data(a_data), .i_round_keys(a_keys),
        .i_valid(a_valid), .o_ready(a_ready), .o_data(a_odata), .o_valid(a_ovalid),
        .i_ready(a_iready)
    );

    inv_cipher_iterative #(.NB_BYTE(8), .N_BYTES(16), .N_ROUNDS(10)) dut128 (
        .i_clock(clk), .i_reset(rst), .i_data(b_data), .i_round_keys(b_keys),
        .i_valid(b_valid), .o_ready(b_ready), .o_data(b_odata), .o_valid(b_ovalid),
        .i_ready(b_iready)
    );

    // Forward AES model: S-box from brute-force inverse plus affine map.
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d = {x, x};
        return d[15-n -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    function automatic logic [KW256-1:0] expand_key(input logic [255:0] key, input int nk);
        logic [31:0]      w [60];
        logic [31:0]      temp;
        logic [7:0]       rc = 8'h01;
        logic [KW256-1:0] rk = '0;
        for (int i = 0; i < 60; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nk+7); i++) begin
            temp = w[i-1];
            if (i % nk == 0) begin
                temp = sub_word({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
                rc   = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                temp = sub_word(temp);
            end
            w[i] = w[i-nk] ^ temp;
        end
        for (int k = 0; k < nk+7; k++) rk[128*k +: 128] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
        return rk;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [KW256-1:0] rk,
                                             input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[127-8*i -: 8];
        for (int rnd = 1; rnd <= nr; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r+4*c] = sbox[s[r + 4*((c+r)%4)]];
            if (rnd != nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = t[i] ^ rk[128*rnd + 127 - 8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (a_ovalid !== 1'b0 || a_odata !== '0) begin
            errors++; $display("FAIL reset_out256: o_valid=%b o_data=%h, want 0 and 0", a_ovalid, a_odata);
        end
        checks++;
        if (b_ovalid !== 1'b0 || b_odata !== '0) begin
            errors++; $display("FAIL reset_out128: o_valid=%b o_data=%h, want 0 and 0", b_ovalid, b_odata);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_ready256: o_ready=%b, want 1", a_ready); end
        checks++;
        if (b_ready !== 1'b1) begin errors++; $display("FAIL reset_ready128: o_ready=%b, want 1", b_ready); end
    endtask

    // FIPS-197 AES-256 block through dut256 with i_ready held high; keys scrambled after acceptance.
    task automatic decrypt_fips256(input string tag);
        @(negedge clk);
        a_data = CT_256; a_keys = rk256; a_valid = 1'b1; a_iready = 1'b1;
        #1;
        checks++;
        if (a_ready !== 1'b1) begin errors++; $display("FAIL %s_ready_idle: o_ready=%b, want 1", tag, a_ready); end
        for (int k = 0; k <= 14; k++) begin
            @(negedge clk);
            if (k == 0) begin a_valid = 1'b0; a_keys = {15{128'hdeadbeef_0badf00d_cafebabe_12345678}}; a_data = '1; end
            checks++;
            if (a_ovalid !== (k == 14)) begin
                errors++; $display("FAIL %s_latency: edge %0d o_valid=%b, want %b", tag, k, a_ovalid, k == 14);
            end
            if (k < 14) begin
                checks++;
                if (a_ready !== 1'b0) begin errors++; $display("FAIL %s_busy_ready: edge %0d o_ready=%b, want 0", tag, k, a_ready); end
            end
        end
        checks++;
        if (a_odata !== PT_FIPS) begin errors++; $display("FAIL %s_data: got %h want %h", tag, a_odata, PT_FIPS); end
        @(negedge clk);
        checks++;
        if (a_ovalid !== 1'b0 || a_odata !== PT_FIPS) begin
            errors++; $display("FAIL %s_consume: o_valid=%b o_data=%h, want 0 and %h", tag, a_ovalid, a_odata, PT_FIPS);
        end
    endtask

    task automatic test_aes256();
        decrypt_fips256("aes256");
    endtask

    task automatic test_aes128();
        @(negedge clk);
        b_data = CT_128; b_keys = rk128[KW128-1:0]; b_valid = 1'b1; b_iready = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (k == 0) begin b_valid = 1'b0; b_keys = '0; end
            checks++;
            if (b_ovalid !== (k == 10)) begin
                errors++; $display("FAIL aes128_latency: edge %0d o_valid=%b, want %b", k, b_ovalid, k == 10);
            end
        end
        checks++;
        if (b_odata !== PT_FIPS) begin errors++; $display("FAIL aes128_data: got %h want %h", b_odata, PT_FIPS); end
    endtask

    task automatic test_backpressure();
        int n = 0;
        @(negedge clk);
        a_data = CT_256; a_keys = rk256; a_valid = 1'b1; a_iready = 1'b0;
        @(negedge clk);
        a_valid = 1'b0;
        while (a_ovalid !== 1'b1 && n < 30) begin @(negedge clk); n++; end
        checks++;
        if (a_ovalid !== 1'b1) begin errors++; $display("FAIL bp_timeout: o_valid=%b after %0d cycles, want 1", a_ovalid, n); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (a_ovalid !== 1'b1 || a_odata !== PT_FIPS || a_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold: cycle %0d valid=%b ready=%b data=%h, want 1 0 %h", i, a_ovalid, a_ready, a_odata, PT_FIPS);
            end
        end
        a_iready = 1'b1;
        #1;
        checks++;
        if (a_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: o_ready=%b, want 1", a_ready); end
        @(negedge clk);
        checks++;
        if (a_ovalid !== 1'b0 || a_ready !== 1'b1 || a_odata !== PT_FIPS) begin
            errors++; $display("FAIL bp_idle: valid=%b ready=%b data=%h, want 0 1 %h", a_ovalid, a_ready, a_odata, PT_FIPS);
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0]     kb = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        logic [127:0]     pb = 128'hffeeddccbbaa99887766554433221100;
        logic [KW256-1:0] rkb;
        logic [127:0]     cb;
        rkb = expand_key(kb, 8);
        cb  = encrypt(pb, rkb, 14);
        @(negedge clk);
        a_data = CT_256; a_keys = rk256; a_valid = 1'b1; a_iready = 1'b1;
        @(negedge clk);
        a_data = cb; a_keys = rkb;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            checks++;
            if (a_ovalid !== (k == 14)) begin
                errors++; $display("FAIL b2b_first_latency: edge %0d o_valid=%b, want %b", k, a_ovalid, k == 14);
            end
        end
        checks++;
        if (a_odata !== PT_FIPS || a_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_first: data=%h ready=%b, want %h 1", a_odata, a_ready, PT_FIPS);
        end
        @(negedge clk);
        a_valid = 1'b0;
        checks++;
        if (a_ovalid !== 1'b0 || a_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_swap: valid=%b ready=%b, want 0 0", a_ovalid, a_ready);
        end
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            checks++;
            if (a_ovalid !== (k == 14)) begin
                errors++; $display("FAIL b2b_second_latency: edge %0d o_valid=%b, want %b", k, a_ovalid, k == 14);
            end
        end
        checks++;
        if (a_odata !== pb) begin errors++; $display("FAIL b2b_second: got %h want %h", a_odata, pb); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        a_data = CT_256; a_keys = rk256; a_valid = 1'b1; a_iready = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (a_ovalid !== 1'b0 || a_odata !== '0 || a_ready !== 1'b1) begin
            errors++; $display("FAIL midreset_async: valid=%b data=%h ready=%b, want 0 0 1", a_ovalid, a_odata, a_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        decrypt_fips256("after_reset");
    endtask

    task automatic test_random();
        localparam int N_BLOCKS = 1000;
        logic [127:0]     exp_q [$];
        logic [127:0]     pend = '0;
        logic [127:0]     e;
        logic [255:0]     key;
        logic [KW256-1:0] rk;
        int               sent = 0;
        int               got = 0;
        int               cyc = 0;
        bit               offering = 1'b0;
        while (got < N_BLOCKS && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (!offering && sent < N_BLOCKS && $urandom_range(0, 3) != 0) begin
                key  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                pend = {$urandom, $urandom, $urandom, $urandom};
                rk   = expand_key(key, 8);
                a_keys  = rk;
                a_data  = encrypt(pend, rk, 14);
                a_valid = 1'b1;
                offering = 1'b1;
            end else if (!offering) begin
                a_valid = 1'b0;
            end
            a_iready = ($urandom_range(0, 3) != 0);
            #1;
            if (a_ovalid && a_iready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_unexpected: output %h with nothing outstanding", a_odata);
                end else begin
                    e = exp_q.pop_front();
                    if (a_odata !== e) begin errors++; $display("FAIL rand_data: block %0d got %h want %h", got, a_odata, e); end
                end
                got++;
            end
            if (a_valid && a_ready) begin
                exp_q.push_back(pend);
                sent++;
                offering = 1'b0;
            end
        end
        checks++;
        if (got != N_BLOCKS || exp_q.size() != 0) begin
            errors++; $display("FAIL rand_count: received %0d of %0d, %0d outstanding", got, N_BLOCKS, exp_q.size());
        end
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = '0;
            for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        rk256 = expand_key(KEY_256, 8);
        rk128 = expand_key(KEY_128, 4);
        test_reset();
        test_aes256();
        test_aes128();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inv_cipher_iterative.md
Name: inv_cipher_iterative

Overview:
- Iterative AES inverse cipher: decrypts one 128-bit block by running one inverse round per clock over a single shared inverse-round datapath.
- Decryption-side counterpart of the unrolled encryption round chain.
- Round keys arrive pre-expanded from the key-schedule logic.
- Valid/ready handshake on both input and output sides; one block in flight at a time.

Parameters:
- NB_BYTE, 8, bits per byte; only 8 is legal.
- N_BYTES, 16, bytes per state; only 16 is legal.
- N_ROUNDS, 14, AES round count; legal values are 10, 12 and 14.

Ports:
- i_clock  in  1  single clock; all flops on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_data  in  128  ciphertext block; byte 0 = bits [127:120] (FIPS-197 order).
- i_round_keys  in  128*(N_ROUNDS+1)  expanded keys; key k = bits [128*k+127 : 128*k].
- i_valid  in  1  input block and keys are valid.
- o_ready  out  1  block can accept input this cycle.
- o_data  out  128  plaintext block.
- o_valid  out  1  o_data is valid.
- i_ready  in  1  downstream accepts o_data.

Behaviour:
- Reset: o_valid=0, o_data=0, internal state register=0, round counter=0, FSM=IDLE. Reset takes effect asynchronously, including mid-operation; the in-flight block is discarded and produces no output.
- o_ready = (FSM==IDLE) | (FSM==DONE & i_ready). It is combinational and does not depend on i_valid.
- Accept: an edge with i_valid & o_ready.
  - state <= i_data ^ key[N_ROUNDS].
  - All keys latched into a key register, so i_round_keys may change after acceptance.
  - cnt <= N_ROUNDS-1; FSM -> BUSY.
- BUSY: each edge applies state <= inv_round(state, key[cnt]).
  - Round operation order: InvShiftRows, InvSubBytes, XOR key[cnt], then InvMixColumns.
  - InvMixColumns is skipped when cnt==0.
  - When cnt>0: cnt decrements.
  - When cnt==0: o_data <= result, o_valid <= 1, FSM -> DONE.
- Latency: o_valid rises N_ROUNDS edges after the acceptance edge (14 for AES-256). Throughput is one block per N_ROUNDS+1 cycles with back-to-back acceptance.
- DONE: o_data/o_valid hold stable until i_ready=1.
  - On an i_ready edge without a new input: o_valid <= 0, FSM -> IDLE. o_data keeps its last value.
  - On an i_ready edge with i_valid=1 in the same cycle: output is consumed and the new block is accepted on that edge. FSM -> BUSY, o_valid <= 0 on that edge.
- i_valid in BUSY is ignored (o_ready=0); the upstream must hold its data.
- i_ready outside DONE has no effect.
- Arithmetic: GF(2^8) with polynomial x^8+x^4+x^3+x+1. InvMixColumns coefficients are {0e,0b,0d,09}.
- FSM states: IDLE, BUSY, DONE. Encoding is free; unreachable codes return to IDLE.
- Illegal NB_BYTE/N_BYTES/N_ROUNDS: elaboration-time error.

Decomposition:
- Shared include (aes_inv_defs.vh):
  - Constants: NB_STATE=128, N_COLS=4, FSM state codes.
  - Functions: inv_sbox byte lookup, gf_mul2/gf_mul by {09,0b,0d,0e}.
- Sub-module inv_round_block: purely combinational.
  - Ports: o_state, i_state, i_round_key, i_last (skip InvMixColumns).
  - Instantiated once. Verified standalone against a reference model, one round at a time.
- Top level holds the FSM, counter, state/key/output registers and key mux.

Test Plan:
- AES-256 vector, key 000102..1f, ciphertext 8ea2b7ca516745bfeafc49904b496089, i_ready=1 -> o_data=00112233445566778899aabbccddeeff, o_valid rises exactly 14 edges after acceptance, o_ready=0 throughout BUSY.
- N_ROUNDS=10, key 000102..0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a -> plaintext 00112233445566778899aabbccddeeff after 10 edges.
- Backpressure: hold i_ready=0 for 20 cycles after o_valid -> o_data/o_valid stable, o_ready=0 until i_ready=1. Then one-cycle handshake -> IDLE.
- Back-to-back: i_valid held high with a new block, i_ready=1 -> second block accepted on the same edge the first is consumed. Two correct results 15 cycles apart; i_round_keys changed after the first acceptance does not corrupt the first result.
- Reset mid-operation: assert i_reset at round 7 -> o_valid=0, o_data=0, o_ready=1 immediately (asynchronous). Next block decrypts correctly with no stale output.
- Random regression: 1000 random keys/blocks with random i_valid/i_ready gaps -> every output matches the model, in order, with no drops or duplicates.
